// File: rtl/key_line_buffer.sv
// Editable keyboard line buffer with a commit handshake to the calculator.
// It has two registered read ports, one for the calculator and one for the display.
module key_line_buffer #(
  parameter int          DEPTH         = 64,
  parameter int          AW            = 6,
  parameter int          CW            = 8,
  parameter logic [CW-1:0] CR_CODE     = 8'h0D,
  parameter logic [CW-1:0] BS_CODE     = 8'h08,
  parameter logic [CW-1:0] ESC_CODE    = 8'h1B,
  parameter bit          CLEAR_ON_DONE = 1'b1
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic [CW-1:0] ascii_in,
  input  logic          data_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  input  logic [AW-1:0] disp_addr,
  output logic [CW-1:0] disp_data,
  output logic [AW:0]   line_len,
  output logic          calc_start,
  input  logic          calc_done,
  output logic          busy,
  output logic          overflow,
  output logic          dropped
);

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [CW-1:0] P_LO    = CW'(8'h20);
  localparam logic [CW-1:0] P_HI    = CW'(8'h7E);

  state_t        r_state;
  state_t        w_nstate;
  logic [CW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_len;
  logic [AW:0]   w_len_nxt;
  logic          r_dr_q;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          r_drop;
  logic          w_drop;
  logic          r_start;
  logic          r_busy;
  logic          w_wr;
  logic [CW-1:0] r_rd;
  logic [CW-1:0] r_disp;
  logic          w_acc;
  logic          w_print;
  logic          w_full;
  logic          w_empty;

  assign w_acc   = data_ready & ~r_dr_q;
  assign w_print = (ascii_in >= P_LO) && (ascii_in <= P_HI);
  assign w_full  = (r_len == L_DEPTH);
  assign w_empty = (r_len == '0);

  always_ff @(posedge clk_50m) begin
    if (rst) r_state <= S_EDIT;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate  = r_state;
    w_wr      = 1'b0;
    w_len_nxt = r_len;
    w_ovf_nxt = r_ovf;
    w_drop    = 1'b0;
    case (r_state)
      S_EDIT: begin
        if (w_acc) begin
          if (w_print) begin
            if (!w_full) begin
              w_wr      = 1'b1;
              w_len_nxt = r_len + L_ONE;
            end else begin
              w_ovf_nxt = 1'b1;
              w_drop    = 1'b1;
            end
          end else if (ascii_in == BS_CODE) begin
            if (!w_empty) w_len_nxt = r_len - L_ONE;
          end else if (ascii_in == ESC_CODE) begin
            w_len_nxt = '0;
            w_ovf_nxt = 1'b0;
          end else if (ascii_in == CR_CODE) begin
            if (!w_empty) w_nstate = S_START;
          end
        end
      end
      S_START: begin
        w_nstate = S_BUSY;
        w_drop   = w_acc;
      end
      S_BUSY: begin
        w_drop = w_acc;
        if (calc_done) begin
          w_nstate = S_EDIT;
          if (CLEAR_ON_DONE) begin
            w_len_nxt = '0;
            w_ovf_nxt = 1'b0;
          end
        end
      end
      default: w_nstate = S_EDIT;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_dr_q  <= 1'b0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_dr_q  <= data_ready;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
      r_drop  <= w_drop;
      r_start <= (w_nstate == S_START);
      r_busy  <= (w_nstate != S_EDIT);
    end
  end

  // RAM is never cleared; the old line_len gates every read
  always_ff @(posedge clk_50m) begin
    if (w_wr) r_mem[r_len[AW-1:0]] <= ascii_in;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_rd   <= '0;
      r_disp <= '0;
    end else begin
      r_rd   <= ({1'b0, rd_addr} < r_len) ? r_mem[rd_addr] : '0;
      r_disp <= ({1'b0, disp_addr} < r_len) ? r_mem[disp_addr] : '0;
    end
  end

  assign rd_data    = r_rd;
  assign disp_data  = r_disp;
  assign line_len   = r_len;
  assign calc_start = r_start;
  assign busy       = r_busy;
  assign overflow   = r_ovf;
  assign dropped    = r_drop;

endmodule

// File: tb/tb_key_line_buffer.sv
// Scoreboard bench for key_line_buffer.
// A queue-based line model feeds a monitor that checks the DUT on each falling edge.
module tb_key_line_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic         clk_50m;
  logic         rst;
  logic [7:0]   ascii_in;
  logic         data_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]   rd_data;
  logic [AW-1:0] disp_addr;
  logic [7:0]   disp_data;
  logic [AW:0]  line_len;
  logic         calc_start;
  logic         calc_done;
  logic         busy;
  logic         overflow;
  logic         dropped;

  key_line_buffer #(
    .DEPTH(DEPTH),
    .AW(AW),
    .CW(8),
    .CLEAR_ON_DONE(1'b1)
  ) dut (
    .clk_50m(clk_50m),
    .rst(rst),
    .ascii_in(ascii_in),
    .data_ready(data_ready),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .line_len(line_len),
    .calc_start(calc_start),
    .calc_done(calc_done),
    .busy(busy),
    .overflow(overflow),
    .dropped(dropped)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  typedef struct {
    logic [AW:0] len;
    logic        busy;
    logic        start;
    logic        drop;
    logic        ovf;
    logic [7:0]  rd;
    logic [7:0]  disp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: the line is a queue of characters.
  logic [7:0] line_q[$];
  int         phase;   // 0 editing, 1 commit cycle, 2 waiting for done
  bit         m_dr;
  bit         m_ovf;
  bit         acc;
  exp_t       e;

  always @(posedge clk_50m) begin
    acc  = data_ready && !m_dr;
    m_dr = data_ready;
    e.drop = 1'b0;
    if (rst) begin
      line_q.delete();
      phase = 0;
      m_ovf = 0;
      m_dr  = 0;
      e.rd   = 8'h00;
      e.disp = 8'h00;
    end else begin
      e.rd   = (int'(rd_addr) < line_q.size()) ? line_q[rd_addr] : 8'h00;
      e.disp = (int'(disp_addr) < line_q.size()) ? line_q[disp_addr] : 8'h00;
      if (phase == 0) begin
        if (acc) begin
          if (ascii_in >= 8'h20 && ascii_in <= 8'h7E) begin
            if (line_q.size() < DEPTH) line_q.push_back(ascii_in);
            else begin
              m_ovf  = 1;
              e.drop = 1'b1;
            end
          end else if (ascii_in == 8'h08) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
          end else if (ascii_in == 8'h1B) begin
            line_q.delete();
            m_ovf = 0;
          end else if (ascii_in == 8'h0D) begin
            if (line_q.size() > 0) phase = 1;
          end
        end
      end else if (phase == 1) begin
        e.drop = acc;
        phase  = 2;
      end else begin
        e.drop = acc;
        if (calc_done) begin
          phase = 0;
          line_q.delete();
          m_ovf = 0;
        end
      end
    end
    e.len   = (AW+1)'(line_q.size());
    e.busy  = (phase != 0);
    e.start = (phase == 1);
    e.ovf   = m_ovf;
    sb.push_back(e);
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t m;
  always @(negedge clk_50m) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk("line_len", 8'(line_len), 8'(m.len));
      chk("busy", 8'(busy), 8'(m.busy));
      chk("calc_start", 8'(calc_start), 8'(m.start));
      chk("dropped", 8'(dropped), 8'(m.drop));
      chk("overflow", 8'(overflow), 8'(m.ovf));
      chk("rd_data", rd_data, m.rd);
      chk("disp_data", disp_data, m.disp);
    end
  end

  bit rnd_addr = 0;
  bit rnd_done = 0;

  task automatic tick();
    @(posedge clk_50m);
    #1;
    if (rnd_addr) begin
      rd_addr   = AW'($urandom_range(0, 15));
      disp_addr = AW'($urandom_range(0, 15));
    end
    if (rnd_done) calc_done = ($urandom_range(0, 7) == 0);
  endtask

  task automatic key(input logic [7:0] c, input int hold, input int gap);
    ascii_in   = c;
    data_ready = 1'b1;
    repeat (hold) tick();
    data_ready = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic done_pulse();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    repeat (2) tick();
  endtask

  logic [7:0] pick;

  initial begin
    rst        = 1'b1;
    ascii_in   = 8'h00;
    data_ready = 1'b0;
    rd_addr    = '0;
    disp_addr  = '0;
    calc_done  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    key(8'h31, 5, 2);
    key(8'h2B, 5, 2);
    key(8'h32, 5, 2);
    for (int a = 0; a < 5; a++) begin
      rd_addr   = AW'(a);
      disp_addr = AW'(4 - a);
      tick();
    end
    key(8'h1B, 2, 2);

    key(8'h31, 2, 1);
    key(8'h32, 2, 1);
    key(8'h08, 2, 1);
    key(8'h33, 2, 1);
    rd_addr   = 4'd1;
    disp_addr = 4'd0;
    key(8'h0D, 1, 0);
    key(8'h37, 1, 3);
    done_pulse();
    key(8'h0D, 3, 3);

    for (int i = 0; i < 9; i++) key(8'h31 + 8'(i), 1, 1);
    rd_addr = 4'd7;
    key(8'h39, 1, 1);
    key(8'h1B, 1, 2);

    key(8'h34, 1, 1);
    key(8'h35, 1, 1);
    key(8'h0D, 1, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    key(8'h39, 1, 1);
    key(8'h0D, 1, 3);
    done_pulse();

    key(8'h41, 100, 2);
    rd_addr   = 4'd0;
    disp_addr = 4'd0;
    repeat (2) tick();
    key(8'h1B, 1, 1);

    rnd_addr = 1;
    rnd_done = 1;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       pick = 8'h08;
        1:       pick = 8'h1B;
        2:       pick = 8'h0D;
        3:       pick = 8'($urandom_range(0, 31));
        4:       pick = 8'($urandom_range(127, 255));
        default: pick = 8'($urandom_range(32, 126));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      key(pick, $urandom_range(1, 4), $urandom_range(0, 3));
    end
    rnd_addr  = 0;
    rnd_done  = 0;
    calc_done = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
